// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: FSM encodings, default bit timing and the parity helper
// used by both the receiver and the transmitter.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  // Even parity: data bits plus parity bit must XOR to zero; returns 1 on mismatch.
  function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction

endpackage

// File: rtl/uart_rx_core_sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value; shared with the
// transmitter's CTS input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 deserialiser with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even parity bit and the parity_err pulse.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]     bit_r, bit_nxt_s;
  logic                 brk_r, brk_nxt_s;
  logic                 shift_en_s, done_s, ferr_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, frame_err_r, overrun_r, busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_smp_s, par_bit_r, parity_err_r;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // FSM state and bit-timing counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= BIT_ZERO;
      brk_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      brk_r   <= brk_nxt_s;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_W'(1);
    bit_nxt_s   = bit_r;
    brk_nxt_s   = brk_r;
    shift_en_s  = 1'b0;
    done_s      = 1'b0;
    ferr_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        bit_nxt_s = BIT_ZERO;
        brk_nxt_s = 1'b0;
        if (!rxd_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == CNT_MID) begin
          cnt_nxt_s = CNT_ZERO;
          if (!rxd_s) state_nxt_s = ST_DATA;
          else        state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          shift_en_s = 1'b1;
          if (bit_r == BIT_LAST) begin
            bit_nxt_s = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            bit_nxt_s = bit_r + BIT_W'(1);
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          par_smp_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // After a bad stop bit, hold here until the line idles so a break cannot restart.
        if (brk_r) begin
          if (rxd_s) state_nxt_s = ST_IDLE;
          else       state_nxt_s = ST_STOP;
        end else if (cnt_r == CNT_LAST) begin
          if (rxd_s) begin
            done_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_s    = 1'b1;
            brk_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // LSB-first shift register and sampled parity bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= {DATA_BITS{1'b0}};
`ifdef UART_RX_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      if (shift_en_s) shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
      else            shift_r <= shift_r;
`ifdef UART_RX_PARITY_EN
      if (par_smp_s) par_bit_r <= rxd_s;
      else           par_bit_r <= par_bit_r;
`endif
    end
  end

  // Holding register, handshake and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_r    <= {DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= ferr_s;
      overrun_r   <= done_s && rx_valid_r && !rx_ready;
      busy_r      <= (state_nxt_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      parity_err_r <= done_s && even_parity_err(8'(shift_r), par_bit_r);
`endif
      if (done_s && (!rx_valid_r || rx_ready)) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames, a frame-level timing model checked every
// cycle, and literal expectations for latency, data and flag counts.
module tb_uart_rx_core;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR     = 1;
  localparam int LAT_LIT = 171;
`else
  localparam int PAR     = 0;
  localparam int LAT_LIT = 155;
`endif
  // Edge (counted from the edge after rxd falls) at which the stop bit is judged.
  localparam int DONE_OFF = 2 + CPB / 2 + (DB + 1 + PAR) * CPB + 1;

  logic          clk, rst, rxd, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  typedef struct {
    int       at;
    bit       good;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         n_checks = 0, n_pass = 0;
  logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0, rise_cyc = 0, last_fall = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame-level model: each sent frame is judged at a known edge; delivery rules applied there.
  initial begin
    forever begin
      ev_t ev;
      logic acc, loaded;
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
        evq.delete();
      end else begin
        m_ferr = 1'b0; m_ovr = 1'b0; loaded = 1'b0;
        acc = m_valid && rx_ready;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (ev.good) begin
            if (!m_valid || rx_ready) begin
              m_data = ev.data; m_valid = 1'b1; loaded = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end else begin
            m_ferr = 1'b1;
          end
        end
        if (acc && !loaded) m_valid = 1'b0;
      end
      #1;
      chk("rx_valid", rx_valid, m_valid);
      if (m_valid) chk("rx_data", rx_data, m_data);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", parity_err, 1'b0);
`endif
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && !prev_valid) begin
        rise_cnt++; rise_cyc = cyc; rise_data = rx_data;
      end
      prev_valid = rx_valid;
    end
  end

  function automatic logic line_bit(input logic [7:0] d, input int idx, input int stop_low);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
    if (PAR == 1 && idx == DB + 1) return ^d;
    if (idx < 1 + DB + PAR + stop_low) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; optional rx_ready pulse at offset rdy_k, optional reset at abort_k.
  task automatic send(input logic [7:0] d, input int stop_low, input int rdy_k, input int abort_k);
    int nbits;
    ev_t ev;
    nbits = 1 + DB + PAR + stop_low + 1;
    for (int k = 0; k < nbits * CPB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        last_fall = cyc;
        ev.at = cyc + DONE_OFF; ev.good = (stop_low == 0); ev.data = d;
        evq.push_back(ev);
      end
      if (k == abort_k) begin
        rst = 1'b0; rxd = 1'b1;
        return;
      end
      rxd = line_bit(d, k / CPB, stop_low);
      if (rdy_k >= 0 && k == rdy_k) rx_ready = 1'b1;
      else if (rdy_k >= 0 && k == rdy_k + 1) rx_ready = 1'b0;
    end
  endtask

  initial begin
    int r0, f0, o0, g, el;
    rst = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    idle(3);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    idle(5);

    // Basic byte with consumer always ready.
    rx_ready = 1'b1; r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send(8'hA5, 0, -1, -1);
    idle(20);
    chk("basic_latency", rise_cyc - last_fall, LAT_LIT);
    chk("basic_data", rise_data, 8'hA5);
    chk("basic_rises", rise_cnt - r0, 1);
    chk("basic_valid_gone", rx_valid, 1'b0);
    chk("basic_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Start-bit glitch.
    r0 = rise_cnt; f0 = ferr_cnt;
    @(negedge clk); g = cyc; rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    chk("glitch_busy_high", busy, 1'b1);
    el = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (!busy) begin el = cyc - g; break; end
    end
    chk("glitch_idle_within_11", (el > 0 && el <= 11), 1'b1);
    idle(20);
    chk("glitch_no_byte", rise_cnt - r0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);

    // Framing error (stop low 3 bit times), then a clean frame.
    r0 = rise_cnt; f0 = ferr_cnt;
    send(8'h3C, 3, -1, -1);
    idle(40);
    chk("ferr_pulses", ferr_cnt - f0, 1);
    chk("ferr_no_byte", rise_cnt - r0, 0);
    send(8'h81, 0, -1, -1);
    idle(20);
    chk("after_ferr_data", rise_data, 8'h81);
    chk("after_ferr_rises", rise_cnt - r0, 1);

    // Backpressure: second byte is dropped.
    rx_ready = 1'b0; r0 = rise_cnt; o0 = ovr_cnt;
    send(8'h11, 0, -1, -1);
    send(8'h22, 0, -1, -1);
    idle(10);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    idle(5);
    chk("ovr_drained", rx_valid, 1'b0);
    chk("ovr_one_byte", rise_cnt - r0, 1);

    // Accept and load in the same cycle.
    o0 = ovr_cnt;
    send(8'h55, 0, -1, -1);
    idle(5);
    chk("hold_55", rx_data, 8'h55);
    send(8'hAA, 0, DONE_OFF - 1, -1);
    idle(3);
    chk("swap_valid", rx_valid, 1'b1);
    chk("swap_data", rx_data, 8'hAA);
    chk("swap_no_ovr", ovr_cnt - o0, 0);

    // Reset during data bit 4 while 0xAA is still held.
    send(8'hF0, 0, -1, (1 + 4) * CPB + CPB / 2);
    #1;
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_flags", {frame_err, overrun}, 2'b00);
    idle(3);
    rst = 1'b1;
    idle(5);
    r0 = rise_cnt; rx_ready = 1'b1;
    send(8'h0F, 0, -1, -1);
    idle(20);
    chk("post_rst_data", rise_data, 8'h0F);
    chk("post_rst_rises", rise_cnt - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive side of the team's UART link. Deserialises an asynchronous 8N1 serial line into parallel bytes.
- Sits between the board RX pin and any byte-stream consumer.
- Presents each received byte on a valid/ready handshake with a one-entry holding register.
- Pairs with the team's UART transmitter, which uses the same bit timing and frame format.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserts when 0).
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  received byte, valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts the byte when rx_valid&&rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, bit counter=0, sample counter=0.
  - Both synchroniser flops reset to 1.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever presented.
- Input path: rxd passes through a 2-flop synchroniser (rxd_s). All sampling uses rxd_s.
- Sample counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: on rxd_s=0, clear the counter and go to START.
  - START: at count CLKS_PER_BIT/2-1 (mid-bit):
    - rxd_s=0: clear the counter and go to DATA.
    - rxd_s=1: glitch; return to IDLE with no flags.
  - DATA: at count CLKS_PER_BIT-1, shift rxd_s into the shift register MSB-side, so LSB-first bits land correctly.
    - After DATA_BITS samples, go to STOP (or PARITY).
  - STOP: at count CLKS_PER_BIT-1:
    - rxd_s=1: frame complete; go to IDLE.
    - rxd_s=0: pulse frame_err, discard the byte, stay in STOP until rxd_s=1, then go to IDLE. This prevents a break condition from retriggering a start.
- Delivery: on frame complete, in the cycle after the stop sample:
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: old byte is consumed, new byte is loaded, rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: pulse overrun; the old byte is retained and the new byte is dropped.
- rx_valid clears in the cycle after rx_valid&&rx_ready, unless a new byte loads in that same cycle.
- While rx_valid=1, rx_data is stable.
- Latency: rx_valid rises 2 (sync) + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the rxd falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at mid-bit like the data bits.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - Adds output parity_err (1 bit): a one-cycle pulse on mismatch, issued in the frame-complete cycle.
  - A byte with a parity error is still delivered.
- Not defined: no PARITY state and no parity_err port; the frame is 8N1.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4), 3 bits.
  - Default CLKS_PER_BIT and DATA_BITS constants, so TX and RX share bit timing.
- One sub-module, sync_2ff: generic 2-flop synchroniser with parameterised reset value. It is also reused by the TX side's CTS input.

Test Plan:
- Basic byte: CLKS_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready=1.
  - Expect rx_data=0xA5 and a one-cycle rx_valid after 2+8+144+1=155 cycles from the falling edge.
  - frame_err=0, overrun=0.
- Glitch: drive rxd low for 4 cycles, then high.
  - Expect return to IDLE, busy low again within 11 cycles, no rx_valid, no flags.
- Framing error: send 0x3C with the stop bit held low for 3 bit times, then high.
  - Expect a single frame_err pulse and no rx_valid.
  - Next frame 0x81 is received correctly.
- Overrun/backpressure: rx_ready=0, send 0x11 then 0x22 back-to-back.
  - Expect rx_valid=1 with rx_data=0x11 and one overrun pulse at the end of the second frame.
  - Raising rx_ready then yields 0x11 only.
- Simultaneous accept+load: hold rx_valid with 0x55, assert rx_ready exactly in the frame-complete cycle of 0xAA.
  - Expect rx_valid to stay 1, rx_data=0xAA, no overrun.
- Reset mid-frame: assert rst=0 during DATA bit 4 of 0xF0.
  - Expect all outputs 0 and busy=0 immediately.
  - After release, a clean 0x0F is received correctly.
